// File: rtl/spi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Command front-end for an SPI controller. Software queues transactions
// (chip select, length, CPOL/CPHA, TX word) through a valid/ready stream.
// The sequencer issues each one to the controller as a single start request
// and returns the received word through a second valid/ready stream.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command stream handshake (ready = FIFO not full)
//   cmd_cs/len/cpol/cpha     per-transaction controller configuration
//   cmd_data                 TX word, left-aligned (first byte = [31:24])
//   rsp_valid/rsp_ready      response stream handshake
//   rsp_data/len/err         RX word (right-aligned), its length, abort flag
//   spi_scom                 start request to the controller
//   spi_cpol/cpha/len/cs/dtx registered configuration to the controller
//   spi_busy, spi_rx         controller BUSY and received word
//   idle                     nothing executing and nothing queued
//
// Optional feature (compile-time macro SPI_SEQ_TIMEOUT_EN):
//   adds a 16-bit watchdog. A start that is not acknowledged by spi_busy
//   within 16 cycles, or a transfer with spi_busy high for more than
//   TIMEOUT_CYCLES cycles, is aborted and answered with rsp_err=1 and
//   rsp_data=0. Without the macro there is no watchdog and rsp_err is 0.
// ---------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int CS_W           = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CS_W-1:0] cmd_cs,
    input  logic [1:0]      cmd_len,
    input  logic            cmd_cpol,
    input  logic            cmd_cpha,
    input  logic [31:0]     cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [1:0]      rsp_len,
    output logic            rsp_err,
    output logic            spi_scom,
    output logic            spi_cpol,
    output logic            spi_cpha,
    output logic [1:0]      spi_len,
    output logic [CS_W-1:0] spi_cs,
    output logic [31:0]     spi_dtx,
    input  logic            spi_busy,
    input  logic [31:0]     spi_rx,
    output logic            idle
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int CMD_W  = CS_W + 36;
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int RSP_W  = 35;
`else
    localparam int RSP_W  = 34;
`endif
    localparam logic [CMD_AW:0] CMD_PTR_ONE = 1;
    localparam logic [RSP_AW:0] RSP_PTR_ONE = 1;

    // Reject parameter values the pointer arithmetic and watchdog cannot support.
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
        $error("spi_cmd_sequencer: CMD_DEPTH must be a power of 2 and >= 2");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
        $error("spi_cmd_sequencer: RSP_DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("spi_cmd_sequencer: TIMEOUT_CYCLES must fit a 16-bit counter");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_CAPTURE
    } state_t;

    state_t state;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CMD_AW:0]  cmd_wr_ptr, cmd_rd_ptr;
    logic             cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [CMD_W-1:0] cmd_head;

    // The extra pointer bit separates full (wrap bits differ) from empty.
    assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
    assign cmd_full  = (cmd_wr_ptr[CMD_AW] != cmd_rd_ptr[CMD_AW]) &&
                       (cmd_wr_ptr[CMD_AW-1:0] == cmd_rd_ptr[CMD_AW-1:0]);
    assign cmd_ready = ~cmd_full;
    assign cmd_push  = cmd_valid & ~cmd_full;
    assign cmd_pop   = (state == S_LOAD);
    assign cmd_head  = cmd_mem[cmd_rd_ptr[CMD_AW-1:0]];

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr[CMD_AW-1:0]] <= {cmd_cs, cmd_len, cmd_cpol, cmd_cpha, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CMD_PTR_ONE;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CMD_PTR_ONE;
        end
    end

    // ---------------- response FIFO ----------------
    logic [RSP_W-1:0] rsp_mem [RSP_DEPTH];
    logic [RSP_AW:0]  rsp_wr_ptr, rsp_rd_ptr;
    logic             rsp_empty, rsp_full, rsp_push, rsp_pop;
    logic [RSP_W-1:0] rsp_head, rsp_wdata;
    logic             abort;

    assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
    assign rsp_full  = (rsp_wr_ptr[RSP_AW] != rsp_rd_ptr[RSP_AW]) &&
                       (rsp_wr_ptr[RSP_AW-1:0] == rsp_rd_ptr[RSP_AW-1:0]);
    assign rsp_valid = ~rsp_empty;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign rsp_push  = (state == S_CAPTURE) | abort;
    assign rsp_head  = rsp_mem[rsp_rd_ptr[RSP_AW-1:0]];

    // Outputs read as zero while empty so the storage never leaks stale data.
    assign rsp_data  = rsp_valid ? rsp_head[31:0]  : 32'd0;
    assign rsp_len   = rsp_valid ? rsp_head[33:32] : 2'd0;

`ifdef SPI_SEQ_TIMEOUT_EN
    assign rsp_wdata = {abort, spi_len, (abort ? 32'd0 : spi_rx)};
    assign rsp_err   = rsp_valid ? rsp_head[34] : 1'b0;
`else
    assign rsp_wdata = {spi_len, spi_rx};
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr[RSP_AW-1:0]] <= rsp_wdata;
        end
    end

    // A push never meets a full FIFO: a transfer only starts with a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RSP_PTR_ONE;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RSP_PTR_ONE;
        end
    end

    // ---------------- watchdog ----------------
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam logic [15:0] BUSY_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wdog;

    // Counts cycles of an unacknowledged start, then cycles of spi_busy high;
    // it clears whenever neither of those is happening.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == S_START && spi_scom && !spi_busy) begin
            wdog <= wdog + 16'd1;
        end else if (state == S_WAIT_DONE && spi_busy) begin
            wdog <= wdog + 16'd1;
        end else begin
            wdog <= '0;
        end
    end

    // Abort on the 16th unacknowledged start cycle, or once busy has been
    // high for more than the configured limit.
    always_comb begin
        abort = 1'b0;
        if (state == S_START && spi_scom && !spi_busy && wdog == 16'd15) abort = 1'b1;
        if (state == S_WAIT_DONE && spi_busy && wdog >= BUSY_LIMIT)      abort = 1'b1;
    end
`else
    assign abort = 1'b0;
`endif

    // ---------------- sequencer FSM ----------------
    // LOAD registers the configuration one cycle before START raises spi_scom,
    // so the controller always sees a settled setup when the start arrives.
    // The configuration is held until CAPTURE, where the chip select is
    // released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            spi_scom <= 1'b0;
            spi_cpol <= 1'b0;
            spi_cpha <= 1'b0;
            spi_len  <= 2'd0;
            spi_dtx  <= 32'd0;
            spi_cs   <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    // No in-flight transfer here, so a free slot is simply !full.
                    if (!cmd_empty && !rsp_full) state <= S_LOAD;
                end
                S_LOAD: begin
                    {spi_cs, spi_len, spi_cpol, spi_cpha, spi_dtx} <= cmd_head;
                    state <= S_START;
                end
                S_START: begin
                    if (abort) begin
                        spi_scom <= 1'b0;
                        spi_cs   <= '1;
                        state    <= S_IDLE;
                    end else if (spi_scom && spi_busy) begin
                        spi_scom <= 1'b0;
                        state    <= S_WAIT_DONE;
                    end else begin
                        spi_scom <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (abort) begin
                        spi_cs <= '1;
                        state  <= S_IDLE;
                    end else if (!spi_busy) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    spi_cs <= '1;
                    state  <= S_IDLE;
                end
                default: begin
                    spi_scom <= 1'b0;
                    spi_cs   <= '1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign idle = (state == S_IDLE) && cmd_empty;

endmodule
